// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the pipelined OTTER
//   core. Owns the fetch PC, runs a req/ack handshake with instruction memory,
//   honours the hazard unit's stalls and the EX-stage redirect, and presents
//   either a real instruction or a NOP bubble to decode.
//
// Ports
//   clk         in   1   clock, rising-edge
//   rst         in   1   asynchronous active-low reset
//   stallF      in   1   hold the fetch PC
//   stallD      in   1   hold the IF/ID register
//   brTakenE    in   1   EX redirect (taken branch/jal/jalr), flushes IF/ID
//   brTargetE   in   32  redirect target PC
//   imem_req    out  1   fetch request
//   imem_addr   out  32  fetch address (pcF, or the held address of a dropped fetch)
//   imem_ack    in   1   fetch complete this cycle, imem_rdata valid
//   imem_rdata  in   32  fetched instruction
//   pcF         out  32  current fetch PC
//   pcD         out  32  IF/ID PC
//   pcPlus4D    out  32  IF/ID PC+4 (wraps modulo 2^32)
//   instrD      out  32  IF/ID instruction
//   validD      out  1   IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        brTakenE,
  input  logic [31:0] brTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic [31:0] instrD,
  output logic        validD
);

  // FETCH: request outstanding at pcF.
  // HOLD : a word was fetched while stalled; it waits in the buffer, no request.
  // DROP : a redirect hit an outstanding request; finish it at the old address
  //        and throw the data away so the memory handshake is never abandoned.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] dropAddr;
  logic [31:0] bufInstr;
  logic [31:0] bufPc;

  logic        hold;
  logic        deliver;
  logic [31:0] deliverPc;
  logic [31:0] deliverInstr;

  assign hold = stallF | stallD;

  // Memory request and address decode; the request is forced low during reset
  // and depends only on state, never on imem_ack.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pcF;
    if (!rst) begin
      imem_req = 1'b0;
    end else if (state == HOLD) begin
      imem_req = 1'b0;
    end else begin
      imem_req = 1'b1;
    end
    case (state)
      DROP:    imem_addr = dropAddr;
      FETCH:   imem_addr = pcF;
      HOLD:    imem_addr = pcF;
      default: imem_addr = pcF;
    endcase
  end

  // Selects whether a real instruction is handed to decode this edge, and from
  // where (memory directly, or the stall buffer when leaving HOLD).
  always_comb begin
    deliver      = 1'b0;
    deliverPc    = pcF;
    deliverInstr = imem_rdata;
    case (state)
      FETCH: begin
        deliver      = imem_ack & ~hold;
        deliverPc    = pcF;
        deliverInstr = imem_rdata;
      end
      HOLD: begin
        deliver      = ~hold;
        deliverPc    = bufPc;
        deliverInstr = bufInstr;
      end
      DROP: begin
        deliver      = 1'b0;
        deliverPc    = pcF;
        deliverInstr = imem_rdata;
      end
      default: begin
        deliver      = 1'b0;
        deliverPc    = pcF;
        deliverInstr = imem_rdata;
      end
    endcase
  end

  // Fetch state machine, PC, stall buffer and IF/ID register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pcF      <= RESET_VEC;
      dropAddr <= 32'h0000_0000;
      bufInstr <= 32'h0000_0000;
      bufPc    <= 32'h0000_0000;
      pcD      <= 32'h0000_0000;
      pcPlus4D <= 32'h0000_0000;
      instrD   <= NOP_INSTR;
      validD   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (brTakenE) begin
            pcF <= brTargetE;
            if (!imem_ack) begin
              // Request still in flight: keep presenting its address until acked.
              state    <= DROP;
              dropAddr <= pcF;
            end
          end else if (imem_ack) begin
            if (!hold) begin
              pcF <= pcF + 32'd4;
            end else begin
              bufInstr <= imem_rdata;
              bufPc    <= pcF;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (brTakenE) begin
            pcF   <= brTargetE;
            state <= FETCH;
          end else if (!hold) begin
            pcF   <= pcF + 32'd4;
            state <= FETCH;
          end
        end
        DROP: begin
          if (brTakenE) begin
            pcF <= brTargetE;
          end
          if (imem_ack) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase

      // IF/ID: flush beats stall beats delivery; anything else is a bubble.
      if (brTakenE) begin
        validD <= 1'b0;
        instrD <= NOP_INSTR;
      end else if (stallD) begin
        validD <= validD;
      end else if (deliver) begin
        pcD      <= deliverPc;
        pcPlus4D <= deliverPc + 32'd4;
        instrD   <= deliverInstr;
        validD   <= 1'b1;
      end else begin
        validD <= 1'b0;
        instrD <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A transaction-level reference model
//   (next PC, an optional buffered word, an optional discarded fetch) predicts
//   the request/address before each edge and the IF/ID contents after it.
//   Directed scenarios come first, then randomized stimulus with resets.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stallF;
  logic        stallD;
  logic        brTakenE;
  logic [31:0] brTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pcF;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic [31:0] instrD;
  logic        validD;

  fetch_stage #(.RESET_VEC(RESET_VEC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .stallD     (stallD),
    .brTakenE   (brTakenE),
    .brTargetE  (brTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pcF        (pcF),
    .pcD        (pcD),
    .pcPlus4D   (pcPlus4D),
    .instrD     (instrD),
    .validD     (validD)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errCnt = 0;
  int chkCnt = 0;

  // Reference model state.
  logic [31:0] mPc;         // next address to fetch
  bit          mBuffered;   // a fetched word is parked waiting for the stall to clear
  logic [31:0] mBufPc;
  logic [31:0] mBufInstr;
  bit          mDropping;   // an outstanding fetch must complete and be discarded
  logic [31:0] mDropAddr;
  logic [31:0] mPcD;
  logic [31:0] mInstrD;
  bit          mValidD;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc       = RESET_VEC;
    mBuffered = 1'b0;
    mBufPc    = 32'h0;
    mBufInstr = 32'h0;
    mDropping = 1'b0;
    mDropAddr = 32'h0;
    mPcD      = 32'h0;
    mInstrD   = NOP_INSTR;
    mValidD   = 1'b0;
  endtask

  function automatic logic [31:0] modelAddr();
    return mDropping ? mDropAddr : mPc;
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic modelStep(input bit ack, input bit br, input logic [31:0] tgt,
                           input bit sF, input bit sD, input logic [31:0] rd);
    bit          hold;
    bit          got;
    logic [31:0] gPc;
    logic [31:0] gInstr;
    hold   = sF | sD;
    got    = 1'b0;
    gPc    = 32'h0;
    gInstr = 32'h0;
    if (mBuffered) begin
      // no request outstanding, ack is meaningless here
      if (br) begin
        mBuffered = 1'b0;
        mPc       = tgt;
      end else if (!hold) begin
        got       = 1'b1;
        gPc       = mBufPc;
        gInstr    = mBufInstr;
        mBuffered = 1'b0;
        mPc       = mPc + 32'd4;
      end
    end else if (mDropping) begin
      if (br) mPc = tgt;
      if (ack) mDropping = 1'b0;
    end else if (br) begin
      if (!ack) begin
        mDropping = 1'b1;
        mDropAddr = mPc;
      end
      mPc = tgt;
    end else if (ack) begin
      if (!hold) begin
        got    = 1'b1;
        gPc    = mPc;
        gInstr = rd;
        mPc    = mPc + 32'd4;
      end else begin
        mBuffered = 1'b1;
        mBufPc    = mPc;
        mBufInstr = rd;
      end
    end
    if (br) begin
      mValidD = 1'b0;
      mInstrD = NOP_INSTR;
    end else if (sD) begin
      // IF/ID keeps its contents
    end else if (got) begin
      mPcD    = gPc;
      mInstrD = gInstr;
      mValidD = 1'b1;
    end else begin
      mValidD = 1'b0;
      mInstrD = NOP_INSTR;
    end
  endtask

  // One clock cycle: drive, check pre-edge request, advance, check post-edge state.
  task automatic step(input bit ack, input bit br, input logic [31:0] tgt,
                      input bit sF, input bit sD);
    logic [31:0] rd;
    @(negedge clk);
    rd         = memWord(modelAddr());
    imem_ack   = ack;
    brTakenE   = br;
    brTargetE  = tgt;
    stallF     = sF;
    stallD     = sD;
    imem_rdata = rd;
    #1;
    checkVal("imem_req", {31'd0, imem_req}, {31'd0, !mBuffered});
    if (!mBuffered) checkVal("imem_addr", imem_addr, modelAddr());
    checkVal("pcF_pre", pcF, mPc);
    modelStep(ack, br, tgt, sF, sD, rd);
    @(posedge clk);
    #1;
    checkVal("pcF", pcF, mPc);
    checkVal("validD", {31'd0, validD}, {31'd0, mValidD});
    checkVal("instrD", instrD, mInstrD);
    if (mValidD) begin
      checkVal("pcD", pcD, mPcD);
      checkVal("pcPlus4D", pcPlus4D, mPcD + 32'd4);
    end
  endtask

  // Reset asserted mid-cycle with an ack pending; reset values must appear at once.
  task automatic midReset(input string tag);
    @(negedge clk);
    imem_ack   = 1'b1;
    brTakenE   = 1'b0;
    stallF     = 1'b0;
    stallD     = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    rst = 1'b0;
    #1;
    checkVal({tag, "_pcF"}, pcF, RESET_VEC);
    checkVal({tag, "_validD"}, {31'd0, validD}, 32'd0);
    checkVal({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    checkVal({tag, "_instrD"}, instrD, NOP_INSTR);
    checkVal({tag, "_pcD"}, pcD, 32'h0);
    @(posedge clk);
    #1;
    checkVal({tag, "_pcF_edge"}, pcF, RESET_VEC);
    checkVal({tag, "_validD_edge"}, {31'd0, validD}, 32'd0);
    @(negedge clk);
    rst      = 1'b1;
    imem_ack = 1'b0;
    modelReset();
  endtask

  // Run zero-wait fetches until the model's fetch PC reaches a given address.
  task automatic runTo(input logic [31:0] addr);
    for (int i = 0; i < 64; i++) begin
      if (mPc == addr && !mBuffered && !mDropping) return;
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    checkVal("runTo_timeout", mPc, addr);
  endtask

  initial begin
    logic [31:0] tgt;
    bit          ack;
    bit          br;
    bit          sF;
    bit          sD;
    int          ackPct;

    rst        = 1'b0;
    stallF     = 1'b0;
    stallD     = 1'b0;
    brTakenE   = 1'b0;
    brTargetE  = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_pcF", pcF, RESET_VEC);
    checkVal("rst_pcD", pcD, 32'h0);
    checkVal("rst_pcPlus4D", pcPlus4D, 32'h0);
    checkVal("rst_instrD", instrD, NOP_INSTR);
    checkVal("rst_validD", {31'd0, validD}, 32'd0);
    checkVal("rst_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait streaming: one instruction per cycle, pcD trailing pcF.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkVal("stream_pcD", pcD, 32'h1C);

    // Ack every third cycle: address held, bubbles in between, no PC skipped.
    for (int i = 0; i < 12; i++) step((i % 3) == 2, 1'b0, 32'h0, 1'b0, 1'b0);
    checkVal("slow_pcF", pcF, 32'h30);

    // stallD while the word at 0x8 arrives: parked in HOLD, then delivered.
    midReset("rst_a");
    runTo(32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkVal("hold_pcD", pcD, 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkVal("release_pcD", pcD, 32'h8);
    checkVal("release_validD", {31'd0, validD}, 32'd1);

    // Redirect in the same cycle as the ack at 0x10.
    runTo(32'h10);
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    checkVal("br_ack_validD", {31'd0, validD}, 32'd0);
    checkVal("br_ack_addr", imem_addr, 32'h100);

    // Redirect at 0x20 with the ack two cycles later: old address held (DROP).
    step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkVal("drop_addr", imem_addr, 32'h20);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkVal("drop_next_addr", imem_addr, 32'h100);
    checkVal("drop_validD", {31'd0, validD}, 32'd0);

    // Reset while waiting for an ack, and while parked in HOLD.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    midReset("rst_wait");
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    midReset("rst_hold");

    // Wrap-around of pcF and pcPlus4D at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ackPct = (i < 1000) ? 90 : ((i < 2000) ? 50 : 25);
      ack = ($urandom_range(0, 99) < ackPct);
      br  = ($urandom_range(0, 99) < 8);
      sF  = ($urandom_range(0, 99) < 15);
      sD  = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else                           tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 199) == 0) midReset("rst_rand");
      else step(ack, br, tgt, sF, sD);
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
